// File: rtl/multdiv_wb_tracker_pkg.sv
// Shared processor constants for the mult/div writeback tracker.
// Holds the exception status register index, the exception codes written
// to it, the tracker state encoding and the held-result record layout.
package multdiv_wb_tracker_pkg;

  // Exceptions are reported by writing a code into the status register
  // instead of the instruction's destination.
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MUL     = 32'd4;  // multiply overflow
  localparam logic [31:0] EXC_DIV     = 32'd5;  // divide by zero

  localparam int CNT_W = 6;  // watchdog counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Held writeback record: destination, result, exception flag (38 bits)
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } hold_t;

  localparam int HOLD_W = $bits(hold_t);

endpackage

// File: rtl/multdiv_wb_tracker_wb_hold_reg.sv
// wb_hold_reg: enabled register holding the pending writeback record
// {rd, data, exception}.
//   clock  : rising-edge clock
//   reset  : synchronous active-low reset, clears the record
//   i_en   : load i_d this cycle
//   i_d    : record to load
//   o_q    : held record
module wb_hold_reg
  import multdiv_wb_tracker_pkg::*;
#(
  parameter int W = HOLD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (!reset)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/multdiv_wb_tracker.sv
// multdiv_wb_tracker: tracks one outstanding mult/div, stalls decode on
// issue and on register hazards against its destination, and writes the
// result (or an exception code into the status register) back through the
// regfile write port whenever the main pipeline leaves it free.
//   clock, reset           : clock, synchronous active-low reset
//   issue_mul/div, issue_rd: start pulse and destination from decode
//   multdiv_result/exception/RDY : completion from the mult/div unit
//   src_rs/rt, dst_rd(+_use): decode register fields for hazard checks
//   pipe_wb_en/rd          : main pipeline regfile write (has priority)
//   wb_en/rd/data          : tracker regfile write request
//   stall                  : freeze fetch/decode
//   busy                   : operation outstanding (not IDLE)
//   timeout                : sticky watchdog error
module multdiv_wb_tracker
  import multdiv_wb_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mul,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] multdiv_result,
  input  logic        multdiv_exception,
  input  logic        multdiv_RDY,
  input  logic [4:0]  src_rs,
  input  logic [4:0]  src_rt,
  input  logic [4:0]  dst_rd,
  input  logic        src_rs_use,
  input  logic        src_rt_use,
  input  logic        dst_rd_use,
  input  logic        pipe_wb_en,
  input  logic [4:0]  pipe_wb_rd,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        busy,
  output logic        timeout
);

  // Last BUSY count value before the watchdog fires: the count is 0 in the
  // first BUSY cycle, so this is the TIMEOUT_CYC-th BUSY cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state, w_state_nxt;
  logic             r_op_mul, w_op_mul_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_hold_en;
  hold_t            w_hold_d, w_hold_q;
  logic             w_issue;
  logic             w_rd_match;
  logic             w_done;

  wb_hold_reg #(.W(HOLD_W)) u_hold (
    .clock (clock),
    .reset (reset),
    .i_en  (w_hold_en),
    .i_d   (w_hold_d),
    .o_q   (w_hold_q)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_op_mul  <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_mul  <= w_op_mul_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign w_issue = issue_mul | issue_div;

  always_comb begin
    w_state_nxt   = r_state;
    w_op_mul_nxt  = r_op_mul;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    w_hold_en     = 1'b0;
    w_hold_d      = w_hold_q;
    unique case (r_state)
      ST_IDLE: begin
        // RDY is deliberately ignored here: a stale completion must not
        // produce a write.
        if (w_issue) begin
          w_state_nxt   = ST_BUSY;
          w_op_mul_nxt  = issue_mul;  // mul wins if both pulse
          w_cnt_nxt     = '0;
          w_hold_en     = 1'b1;
          w_hold_d.rd   = issue_rd;
          w_hold_d.data = '0;
          w_hold_d.exc  = 1'b0;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (multdiv_RDY) begin
          w_hold_en     = 1'b1;
          w_hold_d.data = multdiv_result;
          w_hold_d.exc  = multdiv_exception;
          // A clean result for r0 has nothing to write back.
          if (w_hold_q.rd == '0 && !multdiv_exception) w_state_nxt = ST_IDLE;
          else                                         w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        // The pipeline owns the write port when it wants it; wait it out.
        if (!pipe_wb_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done = (r_state == ST_DONE);
  assign busy   = (r_state != ST_IDLE);

  // Hazards against r0 never matter, so rd_q==0 disables the compares.
  assign w_rd_match = (w_hold_q.rd != '0) &&
                      ((src_rs_use && src_rs == w_hold_q.rd) ||
                       (src_rt_use && src_rt == w_hold_q.rd) ||
                       (dst_rd_use && dst_rd == w_hold_q.rd));

  assign stall   = busy && (w_issue || w_rd_match);
  assign wb_en   = w_done && !pipe_wb_en;
  assign wb_rd   = !w_done      ? '0 :
                   w_hold_q.exc ? RSTATUS_REG : w_hold_q.rd;
  assign wb_data = !w_done      ? '0 :
                   w_hold_q.exc ? (r_op_mul ? EXC_MUL : EXC_DIV) : w_hold_q.data;
  assign timeout = r_timeout;

  // pipe_wb_rd is informational only; the port arbitration needs just the enable.
  logic w_unused;
  assign w_unused = ^pipe_wb_rd;

endmodule

// File: tb/tb_multdiv_wb_tracker.sv
module tb_multdiv_wb_tracker;
  localparam int TO = 63;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_mul = 0, issue_div = 0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] multdiv_result = '0;
  logic        multdiv_exception = 0, multdiv_RDY = 0;
  logic [4:0]  src_rs = '0, src_rt = '0, dst_rd = '0;
  logic        src_rs_use = 0, src_rt_use = 0, dst_rd_use = 0;
  logic        pipe_wb_en = 0;
  logic [4:0]  pipe_wb_rd = '0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, busy, timeout;

  always #5 clock = ~clock;

  multdiv_wb_tracker #(.TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .issue_mul(issue_mul), .issue_div(issue_div), .issue_rd(issue_rd),
    .multdiv_result(multdiv_result), .multdiv_exception(multdiv_exception),
    .multdiv_RDY(multdiv_RDY),
    .src_rs(src_rs), .src_rt(src_rt), .dst_rd(dst_rd),
    .src_rs_use(src_rs_use), .src_rt_use(src_rt_use), .dst_rd_use(dst_rd_use),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_rd(pipe_wb_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .busy(busy), .timeout(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dut_wr_cnt [32];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an op is either in flight in the unit,
  // or finished and waiting for a free write port, or nothing is pending.
  bit          m_in_flight, m_waiting, m_timeout, m_mul, m_exc;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  int          m_age;

  function automatic void model_update();
    if (!reset) begin
      m_in_flight = 0; m_waiting = 0; m_timeout = 0;
      m_mul = 0; m_exc = 0; m_rd = '0; m_res = '0; m_age = 0;
    end else if (m_waiting) begin
      if (!pipe_wb_en) m_waiting = 0;
    end else if (m_in_flight) begin
      m_age++;
      if (multdiv_RDY) begin
        m_in_flight = 0;
        m_res = multdiv_result;
        m_exc = multdiv_exception;
        m_waiting = (m_rd != 0) || multdiv_exception;
      end else if (m_age == TO) begin
        m_in_flight = 0;
        m_timeout = 1;
      end
    end else if (issue_mul || issue_div) begin
      m_in_flight = 1; m_rd = issue_rd; m_mul = issue_mul; m_age = 0;
      m_exc = 0; m_res = '0;
    end
  endfunction

  task automatic sample();
    logic        e_busy, e_match, e_stall, e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    @(negedge clock);
    e_busy  = m_in_flight || m_waiting;
    e_match = (src_rs_use && src_rs == m_rd) || (src_rt_use && src_rt == m_rd) ||
              (dst_rd_use && dst_rd == m_rd);
    e_stall = e_busy && (issue_mul || issue_div || (m_rd != 0 && e_match));
    e_wb    = m_waiting && !pipe_wb_en;
    e_rd    = !m_waiting ? 5'd0 : (m_exc ? 5'd30 : m_rd);
    e_data  = !m_waiting ? 32'd0 : (m_exc ? (m_mul ? 32'd4 : 32'd5) : m_res);
    chk("busy", busy, e_busy);
    chk("stall", stall, e_stall);
    chk("wb_en", wb_en, e_wb);
    chk("wb_rd", wb_rd, e_rd);
    chk("wb_data", wb_data, e_data);
    chk("timeout", timeout, m_timeout);
    if (wb_en === 1'b1) dut_wr_cnt[wb_rd]++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    issue_mul = 0; issue_div = 0; multdiv_RDY = 0; multdiv_exception = 0;
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin sample(); tick(); end
  endtask

  task automatic clr_decode();
    src_rs_use = 0; src_rt_use = 0; dst_rd_use = 0; pipe_wb_en = 0;
  endtask

  initial begin
    int r7_before;
    for (int i = 0; i < 32; i++) dut_wr_cnt[i] = 0;

    // Reset
    reset = 0; tick(); tick(); reset = 1;
    sample();
    chk("rst_busy", busy, 0); chk("rst_wb_en", wb_en, 0);
    chk("rst_timeout", timeout, 0); chk("rst_stall", stall, 0);
    tick();

    // mul rd=5, RDY 17 cycles after issue
    issue_mul = 1; issue_rd = 5; cyc();
    cyc(16);
    multdiv_RDY = 1; multdiv_result = 32'h30; cyc();
    sample();
    chk("s1_wb_en", wb_en, 1); chk("s1_wb_rd", wb_rd, 5); chk("s1_wb_data", wb_data, 32'h30);
    tick();
    sample(); chk("s1_stall_rel", stall, 0); chk("s1_idle", busy, 0); tick();

    // div rd=7 with exception -> status register gets 5
    r7_before = dut_wr_cnt[7];
    issue_div = 1; issue_rd = 7; cyc(3);
    multdiv_RDY = 1; multdiv_exception = 1; multdiv_result = 32'hdead; cyc();
    sample(); chk("s2_wb_rd", wb_rd, 30); chk("s2_wb_data", wb_data, 5); tick();
    cyc(2);
    chk("s2_r7_unwritten", dut_wr_cnt[7], r7_before);

    // DONE blocked by pipeline for 3 cycles
    issue_mul = 1; issue_rd = 12; cyc(2);
    multdiv_RDY = 1; multdiv_result = 32'h1234; cyc();
    pipe_wb_en = 1;
    for (int k = 0; k < 3; k++) begin sample(); chk("s3_blocked", wb_en, 0); tick(); end
    pipe_wb_en = 0;
    sample(); chk("s3_write", wb_en, 1); tick();
    sample(); chk("s3_single", wb_en, 0); tick();

    // Hazard with rd_q=9, then with rd_q=0
    issue_mul = 1; issue_rd = 9; cyc();
    src_rt = 9; src_rt_use = 1;
    sample(); chk("s4_stall_rd9", stall, 1); tick();
    multdiv_RDY = 1; multdiv_result = 32'h9; cyc(3);
    clr_decode();
    issue_div = 1; issue_rd = 0; cyc();
    src_rt = 0; src_rt_use = 1;
    sample(); chk("s4_stall_rd0", stall, 0); tick();
    multdiv_RDY = 1; cyc(2);
    clr_decode();

    // Reset mid-BUSY, later RDY ignored
    issue_mul = 1; issue_rd = 3; cyc(4);
    reset = 0; cyc(); reset = 1;
    multdiv_RDY = 1; multdiv_result = 32'h77; cyc();
    sample(); chk("s5_no_wb", wb_en, 0); chk("s5_idle", busy, 0); tick();

    // Watchdog
    issue_div = 1; issue_rd = 4; cyc();
    cyc(TO);
    sample(); chk("s6_timeout", timeout, 1); chk("s6_idle", busy, 0); tick();
    issue_mul = 1; issue_rd = 6; cyc(2);
    multdiv_RDY = 1; cyc(2);
    sample(); chk("s6_sticky", timeout, 1); tick();
    reset = 0; cyc(); reset = 1;
    sample(); chk("s6_cleared", timeout, 0); tick();

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      issue_mul         = ($urandom_range(0, 5) == 0);
      issue_div         = ($urandom_range(0, 5) == 0);
      issue_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      multdiv_RDY       = ($urandom_range(0, 9) == 0);
      multdiv_exception = ($urandom_range(0, 3) == 0);
      multdiv_result    = $urandom;
      src_rs     = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      src_rt     = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      dst_rd     = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      src_rs_use = 1'($urandom); src_rt_use = 1'($urandom); dst_rd_use = 1'($urandom);
      pipe_wb_en = 1'($urandom);
      pipe_wb_rd = 5'($urandom);
      reset      = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset = 1;
    clr_decode();
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_wb_tracker.md
MULTDIV_WB_TRACKER -- requirements
Module: multdiv_wb_tracker

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have the ports `issue_mul` and `issue_div`, input, 1 bit each: one-cycle pulses from decode that start a mult/div.
REQ-004 The block SHALL have the port `issue_rd`, input, 5 bits: destination register of the issued mult/div.
REQ-005 The block SHALL have the ports `multdiv_result` (input, 32 bits), `multdiv_exception` (input, 1 bit) and `multdiv_RDY` (input, 1 bit): completion from the multdiv unit.
REQ-006 The block SHALL have the ports `src_rs`, `src_rt` and `dst_rd`, input, 5 bits each: register fields of the instruction in decode.
REQ-007 The block SHALL have the ports `src_rs_use`, `src_rt_use` and `dst_rd_use`, input, 1 bit each: field-valid qualifiers.
REQ-008 The block SHALL have the ports `pipe_wb_en` (input, 1 bit) and `pipe_wb_rd` (input, 5 bits): the main pipeline's regfile write this cycle.
REQ-009 The block SHALL have the ports `wb_en` (output, 1 bit), `wb_rd` (output, 5 bits) and `wb_data` (output, 32 bits): the tracker's regfile write request.
REQ-010 The block SHALL have the port `stall`, output, 1 bit: freeze fetch/decode.
REQ-011 The block SHALL have the port `busy`, output, 1 bit: high when the state is not IDLE.
REQ-012 The block SHALL have the port `timeout`, output, 1 bit: sticky watchdog error.
REQ-013 The block SHALL have the parameter `TIMEOUT_CYC`, default 63: maximum number of BUSY cycles before `timeout` is raised.

Function
REQ-014 The block SHALL implement the states IDLE, BUSY and DONE.
REQ-015 In IDLE, when `issue_mul` or `issue_div` is high, the block SHALL capture `issue_rd` and the op type (mul wins if both are high) and enter BUSY next cycle.
REQ-016 In IDLE, the block SHALL ignore `multdiv_RDY`.
REQ-017 In BUSY, when `multdiv_RDY` is high, the block SHALL capture `multdiv_result` and `multdiv_exception`, then enter DONE next cycle; if the captured rd is 0 and there is no exception, it SHALL enter IDLE instead, with no write.
REQ-018 In BUSY, the block SHALL ignore `issue_mul` and `issue_div`; upstream holds them under `stall`.
REQ-019 In DONE, the block SHALL assert `wb_en` only in cycles where `pipe_wb_en` is 0, because the pipeline has write-port priority; after the cycle with `wb_en`=1 it SHALL enter IDLE, and otherwise it SHALL remain in DONE indefinitely.
REQ-020 Without an exception, the block SHALL drive `wb_rd`=captured rd and `wb_data`=captured result.
REQ-021 With an exception, the block SHALL drive `wb_rd`=30 and `wb_data`=4 for mul overflow or 5 for divide-by-zero.
REQ-022 The block SHALL drive `stall` high when `busy`=1 and any of the following holds: (issue_mul|issue_div); (src_rs_use and src_rs==rd_q); (src_rt_use and src_rt==rd_q); (dst_rd_use and dst_rd==rd_q); where rd_q!=0. When rd_q==0, it SHALL ignore the register matches.
REQ-023 The block SHALL compute `stall` combinationally; it falls the cycle the state returns to IDLE, so there is no bypass in DONE.
REQ-024 A 6-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-025 When the counter reaches `TIMEOUT_CYC`, the block SHALL set `timeout`, return to IDLE with no writeback, and keep `timeout` set until reset.
REQ-026 Latency: issue at cycle T gives BUSY at T+1; RDY at cycle R gives DONE at R+1, with `wb_en` at the earliest in R+1; IDLE and `stall` release at R+2 when the port is free.
REQ-027 When `multdiv_RDY` and a register match occur in the same cycle, `stall` SHALL remain high for that cycle.

Reset
REQ-028 When `reset`=0 at a rising edge, the block SHALL enter IDLE; rd_q, the op type, the result and the counter SHALL clear to 0; and `timeout`, `wb_en`, `wb_rd`, `wb_data`, `busy` and `stall` SHALL all be 0.
REQ-029 When reset is asserted mid-operation in BUSY or DONE, the block SHALL drop the pending result with no write, and it SHALL ignore a later `multdiv_RDY`.

Structure
REQ-030 The constants RSTATUS_REG=30, EXC_MUL=4 and EXC_DIV=5 and the state encoding SHALL live in the shared processor constants package.
REQ-031 The block SHALL contain one sub-module, `wb_hold_reg`: a 38-bit register with enable that holds {rd, data, exception}.

Verification
REQ-032 The bench SHALL cover this scenario: issue_mul with rd=5, RDY 17 cycles later with result=0x0000_0030, pipe_wb_en=0 -> wb_en=1, wb_rd=5, wb_data=0x30 at RDY+1; stall low at RDY+2.
REQ-033 The bench SHALL cover this scenario: issue_div with rd=7, RDY with exception=1 -> wb_rd=30, wb_data=5, and register 7 is not written.
REQ-034 The bench SHALL cover this scenario: in DONE, pipe_wb_en=1 for 3 cycles -> wb_en held at 0 for those 3 cycles, then a single-cycle write.
REQ-035 The bench SHALL cover this scenario: in BUSY with rd_q=9, decode src_rt=9 with use=1 -> stall=1; the same case with rd_q=0 -> stall=0.
REQ-036 The bench SHALL cover this scenario: reset=0 asserted in BUSY, then RDY pulsed -> no wb_en, state IDLE.
REQ-037 The bench SHALL cover this scenario: no RDY for 63 BUSY cycles -> timeout=1, busy=0, and timeout stays 1 until reset.
